mcycle_arbiter: RTL
===================

Name: mcycle_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared multi-cycle multiply/divide unit (MCycle).
- Accepts operation requests over valid/ready, issues each one to MCycle, waits for completion, and returns Result1/Result2 to the originating requester over valid/ready.
- Sits between the pipeline's multi-cycle issue points (e.g. execute stage and a coprocessor/debug port) and the single MCycle instance.

Parameters:
- WIDTH, 4, operand/result width; must equal the MCycle width.
- TIMEOUT, 64, maximum cycles in WAIT_DONE before the error abort; minimum 4.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset (0 = reset).
- req0_valid  in  1  requester 0 has an operation.
- req0_op  in  2  MCycleOp: 00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div.
- req0_a  in  WIDTH  Operand1 (multiplicand/dividend).
- req0_b  in  WIDTH  Operand2 (multiplier/divisor).
- req0_ready  out  1  request 0 accepted this cycle.
- rsp0_valid  out  1  result for requester 0 held valid.
- rsp0_ready  in  1  requester 0 consumes the result.
- req1_*, rsp1_*  same as above for requester 1.
- rsp_r1  out  WIDTH  captured Result1 (product LSW / quotient); shared by both rsp ports.
- rsp_r2  out  WIDTH  captured Result2 (product MSW / remainder).
- rsp_err  out  1  result is invalid due to timeout.
- mc_start  out  1  to MCycle Start.
- mc_op  out  2  to MCycle MCycleOp.
- mc_op1, mc_op2  out  WIDTH  to MCycle Operand1/Operand2.
- mc_result1, mc_result2  in  WIDTH  from MCycle.
- mc_busy  in  1  from MCycle Busy.

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE; all outputs 0; last_grant=1, so requester 0 wins the first tie. Reset mid-operation abandons the transaction with no response. mc_start drops immediately; MCycle is reset by the system reset.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - If any req_valid, grant per round-robin: when both are valid, grant the one not equal to last_grant.
  - reqN_ready=1 (combinational, IDLE only) for the granted N.
  - Latch op, a, b and grant id; update last_grant; go to ISSUE.
  - At most one ready is high per cycle.
- ISSUE: mc_start=1, with mc_op/op1/op2 driven from latches, which stay stable until RESP. Go to WAIT_BUSY.
- WAIT_BUSY: mc_start stays 1 until mc_busy=1 is sampled. Then mc_start=0 and go to WAIT_DONE, so MCycle never back-to-back restarts.
- WAIT_DONE:
  - On mc_busy=0: capture mc_result1/2 into rsp_r1/r2, rsp_err=0, go to RESP.
  - Cycle counter counts from entry into WAIT_BUSY. If it reaches TIMEOUT: rsp_err=1, rsp_r1=rsp_r2=0, go to RESP.
- RESP:
  - rspN_valid=1 for the granted N only; rsp_r1/r2/err held stable.
  - On rspN_ready=1: go to IDLE. New grants are possible the following cycle, not the same cycle.
- Minimum latency: accept at T → mc_start from T+1 → response valid 1 cycle after the Busy falling edge is sampled.
- Request fields are sampled only in the acceptance cycle. Later changes to valid/operands are ignored.
- Inputs rspN_ready while rspN_valid=0 are ignored.
- No queuing: a losing requester keeps valid high and is served next (starvation-free, bound of one transaction).

Decomposition:
- Shared package: MCycleOp encodings (MC_SMUL, MC_UMUL, MC_SDIV, MC_UDIV) and FSM state encoding constants.
- Sub-module rr_arb2: combinational 2-way round-robin grant from (valid0, valid1, last_grant). The FSM, latches and timeout counter stay in the top level.

Test Plan:
- Bench uses the real MCycle (WIDTH=4).
- req0 signed mul a=1111 b=1111 → rsp0_valid with r1=0001, r2=0000, err=0; req1_ready never asserted.
- req1 unsigned mul a=1111 b=1111 → rsp1_valid, r1=0001, r2=1110; mc_start falls the cycle after mc_busy rises.
- Both valid in the same cycle:
  - req0 signed div 0111/1101, req1 unsigned div 1101/0111.
  - Expect req0 served first: r1=1110 (−2), r2=0001.
  - Then req1: r1=0001, r2=0110.
  - Repeat the simultaneous request and expect req1 first (alternation).
- Response backpressure: hold rsp0_ready=0 for 10 cycles.
  - rsp0_valid and r1/r2 remain stable; req1_ready stays 0 throughout.
  - req1 is accepted the cycle after the consuming handshake.
- Timeout: replace MCycle with a stub holding mc_busy=1, TIMEOUT=8 → rsp0_valid with err=1, r1=r2=0, 8 cycles after WAIT_BUSY entry.
- Reset mid-operation: assert RESET=0 during WAIT_DONE.
  - Outputs go to 0 asynchronously, with no rsp_valid.
  - After release, req0 signed mul 1110×1111 → r1=0010, r2=0000.

Source files
------------

// File: rtl/mcycle_arbiter_pkg.sv
// mcycle_arbiter_pkg
//   Shared definitions for the MCycle arbiter slice.
//   - mc_op_e : MCycleOp encodings understood by the multi-cycle unit
//   - state_e : arbiter sequencer states
package mcycle_arbiter_pkg;

  typedef enum logic [1:0] {
    MC_SMUL = 2'b00,
    MC_UMUL = 2'b01,
    MC_SDIV = 2'b10,
    MC_UDIV = 2'b11
  } mc_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } state_e;

endpackage

// File: rtl/mcycle_arbiter_if.sv
// mcycle_arbiter_if
//   One requester's link to the arbiter: a request channel (valid/ready with
//   op and operands) and a response-handshake pair (valid/ready).  The result
//   data itself travels on the arbiter's shared rsp_r1/rsp_r2/rsp_err ports.
//   Modports:
//     master : the requester (drives request fields and rsp_ready)
//     slave  : the arbiter   (drives req_ready and rsp_valid)
interface mcycle_arbiter_if
  import mcycle_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
);

  logic             req_valid;
  mc_op_e           req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_ready;
  logic             rsp_valid;
  logic             rsp_ready;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid
  );

endinterface

// File: rtl/mcycle_arbiter_rr_arb2.sv
// rr_arb2
//   Combinational two-way round-robin grant.
//   Ports:
//     valid0, valid1 : requests
//     last_grant     : id of the requester granted most recently
//     gnt0, gnt1     : one-hot (or zero) grant
//   A lone request is always granted; on a tie the requester that was not
//   granted last time wins.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic gnt0,
  output logic gnt1
);

  assign gnt0 = valid0 & (~valid1 | last_grant);
  assign gnt1 = valid1 & (~valid0 | ~last_grant);

endmodule

// File: rtl/mcycle_arbiter.sv
// mcycle_arbiter
//   Shares one multi-cycle multiply/divide unit (MCycle) between two
//   requesters.  A request is accepted in IDLE, issued to MCycle, and the
//   results are returned to the requester that issued it.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     req0, req1          : requester links (request + response handshake)
//     rsp_r1, rsp_r2      : captured Result1/Result2, shared by both links
//     rsp_err             : result aborted by timeout (r1/r2 forced to 0)
//     mc_start, mc_op,
//     mc_op1, mc_op2      : command to MCycle
//     mc_result1/2,
//     mc_busy             : status/results from MCycle
//   TIMEOUT must be at least 4.
module mcycle_arbiter
  import mcycle_arbiter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  mcycle_arbiter_if.slave  req0,
  mcycle_arbiter_if.slave  req1,
  output logic [WIDTH-1:0] rsp_r1,
  output logic [WIDTH-1:0] rsp_r2,
  output logic             rsp_err,
  output logic             mc_start,
  output mc_op_e           mc_op,
  output logic [WIDTH-1:0] mc_op1,
  output logic [WIDTH-1:0] mc_op2,
  input  logic [WIDTH-1:0] mc_result1,
  input  logic [WIDTH-1:0] mc_result2,
  input  logic             mc_busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state;
  logic          last_grant;
  logic          gid;
  logic [1:0]    rsp_valid_q;
  logic [CW-1:0] tcount;
  logic          gnt0;
  logic          gnt1;

  rr_arb2 u_rr_arb2 (
    .valid0     (req0.req_valid),
    .valid1     (req1.req_valid),
    .last_grant (last_grant),
    .gnt0       (gnt0),
    .gnt1       (gnt1)
  );

  // Ready is only offered in IDLE.  It is also masked by reset so that every
  // output reads 0 while reset is held, even with a request pending.
  assign req0.req_ready = rst_n & (state == ST_IDLE) & gnt0;
  assign req1.req_ready = rst_n & (state == ST_IDLE) & gnt1;

  assign req0.rsp_valid = rsp_valid_q[0];
  assign req1.rsp_valid = rsp_valid_q[1];

  // Sequencer.  Command outputs are latched at acceptance and held until the
  // next grant, so MCycle sees stable operands for the whole transaction.
  // mc_start is raised on acceptance and held until MCycle reports Busy,
  // which guarantees MCycle has seen it exactly once.  The timeout counter
  // starts at WAIT_BUSY entry; the abort fires on its TIMEOUT-th cycle so the
  // error response appears TIMEOUT cycles after WAIT_BUSY entry.  A result
  // that completes on the same cycle as the timeout is still delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_grant  <= 1'b1;
      gid         <= 1'b0;
      mc_start    <= 1'b0;
      mc_op       <= MC_SMUL;
      mc_op1      <= '0;
      mc_op2      <= '0;
      rsp_r1      <= '0;
      rsp_r2      <= '0;
      rsp_err     <= 1'b0;
      rsp_valid_q <= 2'b00;
      tcount      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt0 || gnt1) begin
            gid        <= gnt1;
            last_grant <= gnt1;
            mc_op      <= gnt1 ? req1.req_op : req0.req_op;
            mc_op1     <= gnt1 ? req1.req_a  : req0.req_a;
            mc_op2     <= gnt1 ? req1.req_b  : req0.req_b;
            mc_start   <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tcount <= '0;
          state  <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          tcount <= tcount + 1'b1;
          if (mc_busy) begin
            mc_start <= 1'b0;
            state    <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          tcount <= tcount + 1'b1;
          if (!mc_busy) begin
            rsp_r1      <= mc_result1;
            rsp_r2      <= mc_result2;
            rsp_err     <= 1'b0;
            rsp_valid_q <= gid ? 2'b10 : 2'b01;
            state       <= ST_RESP;
          end else if (tcount == CW'(TIMEOUT - 1)) begin
            rsp_r1      <= '0;
            rsp_r2      <= '0;
            rsp_err     <= 1'b1;
            rsp_valid_q <= gid ? 2'b10 : 2'b01;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (gid ? req1.rsp_ready : req0.rsp_ready) begin
            rsp_valid_q <= 2'b00;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
